// File: rtl/aes_pkg.sv
// ----------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the iterative AES round engine:
//   - sbox / inv_sbox   : forward and inverse S-box lookup tables
//   - xtime / gmul      : GF(2^8) helpers used by (Inv)MixColumns
//   - state_t           : engine FSM states (IDLE, ROUND, DONE)
//   - NR_AES128/192/256 : round counts for the three AES key sizes
// ----------------------------------------------------------------------------
package aes_pkg;

    localparam int NR_AES128 = 10;
    localparam int NR_AES192 = 12;
    localparam int NR_AES256 = 14;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        DONE
    } state_t;

    // Index 0 is the leftmost byte, so sbox[x] is the FIPS-197 table entry.
    localparam logic [0:255][7:0] sbox = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] inv_sbox = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // General GF(2^8) multiply; with a constant b it collapses to a few XORs.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

endpackage

// File: rtl/aes_round_engine_if.sv
// ----------------------------------------------------------------------------
// aes_round_engine_if
// Handshake and key-store bus of the AES round engine.
//   in_valid/in_ready, decrypt_i, data_i : input block handshake
//   rk_addr / rk_data                    : round-key request, combinational reply
//   out_valid/out_ready, data_o          : result handshake
// Modports: master (block source / key store / sink), slave (engine).
// ----------------------------------------------------------------------------
interface aes_round_engine_if #(
    parameter int RK_AW = 4
);
    logic               in_valid;
    logic               in_ready;
    logic               decrypt_i;
    logic [127:0]       data_i;
    logic [RK_AW-1:0]   rk_addr;
    logic [127:0]       rk_data;
    logic               out_valid;
    logic               out_ready;
    logic [127:0]       data_o;

    modport master (
        output in_valid, decrypt_i, data_i, rk_data, out_ready,
        input  in_ready, rk_addr, out_valid, data_o
    );

    modport slave (
        input  in_valid, decrypt_i, data_i, rk_data, out_ready,
        output in_ready, rk_addr, out_valid, data_o
    );
endinterface

// File: rtl/aes_round_dp.sv
// ----------------------------------------------------------------------------
// aes_round_dp
// Combinational AES round: (Inv)SubBytes -> (Inv)ShiftRows -> (Inv)MixColumns
// -> AddRoundKey. MixColumns is skipped when last_round is set.
//   state      : current cipher state
//   round_key  : key XORed at the end of the round
//   decrypt    : 1 selects the inverse transforms
//   last_round : bypass (Inv)MixColumns
//   next_state : result of the round
// Optional macro AES_SBOX_PIPE_EN exposes the split after (Inv)SubBytes as
// sub_d (output) and sub_q (registered input) so the engine can pipeline it.
// ----------------------------------------------------------------------------
module aes_round_dp
    import aes_pkg::*;
(
    input  logic [127:0] state,
    input  logic [127:0] round_key,
    input  logic         decrypt,
    input  logic         last_round,
`ifdef AES_SBOX_PIPE_EN
    output logic [127:0] sub_d,
    input  logic [127:0] sub_q,
`endif
    output logic [127:0] next_state
);

`ifndef AES_SBOX_PIPE_EN
    logic [127:0] sub_d;
    logic [127:0] sub_q;
    assign sub_q = sub_d;
`endif

    logic [127:0] shifted;
    logic [127:0] mixed;

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    endfunction

    // Byte-wise substitution; byte 0 sits in bits [127:120].
    always_comb begin
        sub_d = '0;
        for (int i = 0; i < 16; i++) begin
            sub_d[127 - 8*i -: 8] = decrypt ? inv_sbox[state[127 - 8*i -: 8]]
                                            : sbox[state[127 - 8*i -: 8]];
        end
    end

    // Row r of column c comes from column (c+r) on encrypt and (c-r) on
    // decrypt; state bytes are column-major, so byte index is r + 4*c.
    always_comb begin
        shifted = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shifted[127 - 8*(r + 4*c) -: 8] =
                    sub_q[127 - 8*(r + 4*(decrypt ? ((c + 4 - r) % 4) : ((c + r) % 4))) -: 8];
            end
        end
    end

    // Column mixing, one 32-bit column at a time.
    always_comb begin
        mixed = '0;
        for (int c = 0; c < 4; c++) begin
            mixed[127 - 32*c -: 32] = decrypt ? inv_mix_column(shifted[127 - 32*c -: 32])
                                              : mix_column(shifted[127 - 32*c -: 32]);
        end
    end

    assign next_state = (last_round ? shifted : mixed) ^ round_key;

endmodule

// File: rtl/aes_round_engine.sv
// ----------------------------------------------------------------------------
// aes_round_engine
// Iterative AES encrypt/decrypt of one 128-bit block over NR rounds using a
// single round datapath. Decrypt uses the equivalent inverse cipher; the key
// store must return InvMixColumns-transformed keys for indices 1..NR-1.
//   clk, rst : clock, synchronous active-high reset
//   bus      : aes_round_engine_if.slave (block in, round-key request, result)
// Parameters: NR (10/12/14 rounds), RK_AW (round-key address width, 2^RK_AW > NR)
// Optional macro AES_SBOX_PIPE_EN: registers the SubBytes output, so each
// round takes two cycles and latency becomes 2*NR.
// ----------------------------------------------------------------------------
module aes_round_engine
    import aes_pkg::*;
#(
    parameter int NR    = 10,
    parameter int RK_AW = 4
) (
    input  logic             clk,
    input  logic             rst,
    aes_round_engine_if.slave bus
);

    localparam logic [RK_AW-1:0] NR_A = RK_AW'(NR);

    state_t           fsm_q;
    state_t           fsm_d;
    logic [RK_AW-1:0] rnd;
    logic             mode_r;
    logic [127:0]     state_q;
    logic [127:0]     dp_next;
    logic             last_round;
    logic             round_commit;

`ifdef AES_SBOX_PIPE_EN
    logic             phase;
    logic [127:0]     sub_d;
    logic [127:0]     sub_q;
    // The round result is written only in the second phase.
    assign round_commit = phase;
`else
    assign round_commit = 1'b1;
`endif

    assign last_round = (rnd == NR_A);
    assign bus.data_o = state_q;

    aes_round_dp u_dp (
        .state      (state_q),
        .round_key  (bus.rk_data),
        .decrypt    (mode_r),
        .last_round (last_round),
`ifdef AES_SBOX_PIPE_EN
        .sub_d      (sub_d),
        .sub_q      (sub_q),
`endif
        .next_state (dp_next)
    );

    // Next-state and handshake outputs. In IDLE the key address follows the
    // live decrypt_i so the whitening key is ready on the accepting edge.
    always_comb begin
        fsm_d         = fsm_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.rk_addr   = '0;
        case (fsm_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                bus.rk_addr  = bus.decrypt_i ? NR_A : '0;
                if (bus.in_valid) fsm_d = ROUND;
            end
            ROUND: begin
                bus.rk_addr = mode_r ? (NR_A - rnd) : rnd;
                if (round_commit && last_round) fsm_d = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) fsm_d = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    // State register, round counter and datapath registers. The counter
    // saturates at NR in DONE and is cleared when the result is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= IDLE;
            rnd     <= '0;
            mode_r  <= 1'b0;
            state_q <= '0;
`ifdef AES_SBOX_PIPE_EN
            phase   <= 1'b0;
            sub_q   <= '0;
`endif
        end else begin
            fsm_q <= fsm_d;
            case (fsm_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        mode_r  <= bus.decrypt_i;
                        state_q <= bus.data_i ^ bus.rk_data;
                        rnd     <= RK_AW'(1);
                    end
                end
                ROUND: begin
`ifdef AES_SBOX_PIPE_EN
                    phase <= ~phase;
                    if (!phase) sub_q <= sub_d;
`endif
                    if (round_commit) begin
                        state_q <= dp_next;
                        if (!last_round) rnd <= rnd + RK_AW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) rnd <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_round_engine.sv
// ----------------------------------------------------------------------------
// tb_aes_round_engine
// Directed bench for aes_round_engine: FIPS-197 C.1 (NR=10) and C.3 (NR=14)
// encrypt/decrypt, reset behaviour, backpressure and mid-operation reset.
// Round keys (and equivalent-inverse keys) are expanded here from the cipher
// keys and served combinationally on rk_addr.
// ----------------------------------------------------------------------------
module tb_aes_round_engine;

    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KEY256 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
`ifdef AES_SBOX_PIPE_EN
    localparam int LAT_MUL = 2;
`else
    localparam int LAT_MUL = 1;
`endif

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         decrypt;
    logic         use14;
    logic         key_dec;
    logic         out_ready;
    logic [127:0] data_in;

    logic [127:0] ek10 [16];
    logic [127:0] dk10 [16];
    logic [127:0] ek14 [16];
    logic [127:0] dk14 [16];
    logic [127:0] work_ek [16];
    logic [127:0] work_dk [16];

    logic [3:0]   addr_log [32];
    int           n_addr;
    int           n_checks;
    int           n_fail;

    logic         obs_valid;
    logic         obs_ready;
    logic [127:0] obs_data;
    logic [3:0]   obs_addr;

    aes_round_engine_if #(.RK_AW(4)) bus10 ();
    aes_round_engine_if #(.RK_AW(4)) bus14 ();

    aes_round_engine #(.NR(10), .RK_AW(4)) dut10 (.clk(clk), .rst(rst), .bus(bus10.slave));
    aes_round_engine #(.NR(14), .RK_AW(4)) dut14 (.clk(clk), .rst(rst), .bus(bus14.slave));

    assign bus10.in_valid  = in_valid & ~use14;
    assign bus14.in_valid  = in_valid & use14;
    assign bus10.decrypt_i = decrypt;
    assign bus14.decrypt_i = decrypt;
    assign bus10.data_i    = data_in;
    assign bus14.data_i    = data_in;
    assign bus10.out_ready = out_ready;
    assign bus14.out_ready = out_ready;
    assign bus10.rk_data   = key_dec ? dk10[bus10.rk_addr] : ek10[bus10.rk_addr];
    assign bus14.rk_data   = key_dec ? dk14[bus14.rk_addr] : ek14[bus14.rk_addr];

    assign obs_valid = use14 ? bus14.out_valid : bus10.out_valid;
    assign obs_ready = use14 ? bus14.in_ready  : bus10.in_ready;
    assign obs_data  = use14 ? bus14.data_o    : bus10.data_o;
    assign obs_addr  = use14 ? bus14.rk_addr   : bus10.rk_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] tbXtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] tbGmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = tbXtime(aa);
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse then affine map.
    function automatic logic [7:0] tbSbox(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h00;
        for (int y = 1; y < 256; y++) begin
            if (tbGmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subWord(input logic [31:0] w);
        return {tbSbox(w[31:24]), tbSbox(w[23:16]), tbSbox(w[15:8]), tbSbox(w[7:0])};
    endfunction

    function automatic logic [127:0] tbInvMix(input logic [127:0] k);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            {a0, a1, a2, a3} = k[127 - 32*c -: 32];
            r[127 - 32*c -: 32] = {
                tbGmul(a0, 8'h0e) ^ tbGmul(a1, 8'h0b) ^ tbGmul(a2, 8'h0d) ^ tbGmul(a3, 8'h09),
                tbGmul(a0, 8'h09) ^ tbGmul(a1, 8'h0e) ^ tbGmul(a2, 8'h0b) ^ tbGmul(a3, 8'h0d),
                tbGmul(a0, 8'h0d) ^ tbGmul(a1, 8'h09) ^ tbGmul(a2, 8'h0e) ^ tbGmul(a3, 8'h0b),
                tbGmul(a0, 8'h0b) ^ tbGmul(a1, 8'h0d) ^ tbGmul(a2, 8'h09) ^ tbGmul(a3, 8'h0e)};
        end
        return r;
    endfunction

    // FIPS-197 key expansion into work_ek; work_dk holds the equivalent
    // inverse schedule (InvMixColumns applied to keys 1..nr-1).
    task automatic expandKey(input logic [255:0] key, input int nk, input int nr);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subWord({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = tbXtime(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = subWord(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 16; r++) begin
            work_ek[r] = '0;
            work_dk[r] = '0;
        end
        for (int r = 0; r <= nr; r++) begin
            work_ek[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            work_dk[r] = (r == 0 || r == nr) ? work_ek[r] : tbInvMix(work_ek[r]);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    // Present one block on the selected engine and let it be accepted;
    // returns at the falling edge after the accepting edge.
    task automatic applyStimulus(input logic sel, input logic dec, input logic [127:0] blk);
        @(negedge clk);
        use14    = sel;
        key_dec  = dec;
        decrypt  = dec;
        data_in  = blk;
        in_valid = 1'b1;
        #1;
        checkOutput("in_ready before accept", 128'(obs_ready), 128'd1);
        addr_log[0] = obs_addr;
        n_addr      = 1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Count cycles from acceptance to out_valid, logging rk_addr each cycle.
    task automatic waitResult(input string tag, input int exp_lat, input logic [127:0] exp_data);
        int lat;
        lat = 0;
        while (!obs_valid && lat < 100) begin
            if (n_addr < 32) addr_log[n_addr] = obs_addr;
            n_addr++;
            @(negedge clk);
            lat++;
        end
        checkOutput({tag, " latency"}, 128'(lat), 128'(exp_lat));
        checkOutput({tag, " data_o"}, obs_data, exp_data);
        checkOutput({tag, " in_ready in DONE"}, 128'(obs_ready), 128'd0);
    endtask

    task automatic completeHandshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput({tag, " out_valid after handshake"}, 128'(obs_valid), 128'd0);
        checkOutput({tag, " in_ready after handshake"}, 128'(obs_ready), 128'd1);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        n_addr    = 0;
        rst       = 1'b1;
        in_valid  = 1'b1;
        decrypt   = 1'b0;
        use14     = 1'b0;
        key_dec   = 1'b0;
        out_ready = 1'b0;
        data_in   = PT;

        expandKey(KEY128, 4, 10);
        for (int i = 0; i < 16; i++) begin
            ek10[i] = work_ek[i];
            dk10[i] = work_dk[i];
        end
        expandKey(KEY256, 8, 14);
        for (int i = 0; i < 16; i++) begin
            ek14[i] = work_ek[i];
            dk14[i] = work_dk[i];
        end

        // Reset held with in_valid high: reset values, no acceptance.
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset in_ready", 128'(obs_ready), 128'd1);
        checkOutput("reset out_valid", 128'(obs_valid), 128'd0);
        checkOutput("reset data_o", obs_data, 128'd0);
        checkOutput("reset rk_addr", 128'(obs_addr), 128'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("idle after reset", 128'(obs_ready), 128'd1);

        $display("[TB] C.1 encrypt");
        applyStimulus(1'b0, 1'b0, PT);
        waitResult("c1 enc", 10*LAT_MUL, CT128);
        completeHandshake("c1 enc");

        $display("[TB] C.1 decrypt");
        applyStimulus(1'b0, 1'b1, CT128);
        waitResult("c1 dec", 10*LAT_MUL, PT);
`ifndef AES_SBOX_PIPE_EN
        checkOutput("c1 dec rk_addr count", 128'(n_addr), 128'd11);
        for (int i = 0; i < 11; i++) begin
            checkOutput($sformatf("c1 dec rk_addr[%0d]", i), 128'(addr_log[i]), 128'(10 - i));
        end
`endif
        completeHandshake("c1 dec");

        $display("[TB] C.3 encrypt/decrypt");
        applyStimulus(1'b1, 1'b0, PT);
        waitResult("c3 enc", 14*LAT_MUL, CT256);
        completeHandshake("c3 enc");
        applyStimulus(1'b1, 1'b1, CT256);
        waitResult("c3 dec", 14*LAT_MUL, PT);
        completeHandshake("c3 dec");

        $display("[TB] backpressure");
        applyStimulus(1'b0, 1'b0, PT);
        waitResult("bp first", 10*LAT_MUL, CT128);
        decrypt  = 1'b1;
        key_dec  = 1'b1;
        data_in  = CT128;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("bp out_valid held", 128'(obs_valid), 128'd1);
            checkOutput("bp data_o stable", obs_data, CT128);
            checkOutput("bp in_ready low", 128'(obs_ready), 128'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("bp out_valid after handshake", 128'(obs_valid), 128'd0);
        checkOutput("bp in_ready after handshake", 128'(obs_ready), 128'd1);
        checkOutput("bp decrypt rk_addr in IDLE", 128'(obs_addr), 128'd10);
        n_addr = 1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        waitResult("bp second", 10*LAT_MUL, PT);
        completeHandshake("bp second");

        $display("[TB] reset mid-operation");
        applyStimulus(1'b0, 1'b0, PT);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort out_valid", 128'(obs_valid), 128'd0);
        checkOutput("abort data_o", obs_data, 128'd0);
        checkOutput("abort in_ready", 128'(obs_ready), 128'd1);
        checkOutput("abort rk_addr", 128'(obs_addr), 128'd0);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, PT);
        waitResult("after abort", 10*LAT_MUL, CT128);
        completeHandshake("after abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
